bcd_display_scan: RTL
=====================

# bcd_display_scan

Time-multiplexed 7-segment driver that consumes the 4-bit BCD outputs of a chain of modulus-10 counters and scans them onto a common-cathode multi-digit display. Sits directly downstream of the decade counters: it samples their packed digit values, maps each to segment patterns, and rotates a one-hot digit select at a prescaled rate. Includes a hold (freeze) input, an invalid-digit flag and optional leading-zero blanking.

## Interface
- DIGITS, 4: number of BCD digits scanned (2..8); digit 0 is least significant.
- PRESCALE, 4: clock cycles each digit stays selected (≥1).
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  scan enable; low blanks the display and parks the scanner.
- hold  input  1  high freezes the captured digit values.
- digits_in  input  4*DIGITS  packed BCD digits; digit k at [4k+3:4k].
- seg_out  output  7  segments, active-high; bit 0 = a … bit 6 = g.
- digit_sel  output  DIGITS  one-hot active-high digit strobe; all-zero when blank.
- err  output  1  high while any captured digit is > 9.

## Operation
- Shadow register: captures digits_in on every rising edge where hold=0; retains value while hold=1. Independent of enable.
- FSM states: IDLE, SCAN. IDLE→SCAN on enable=1; SCAN→IDLE on enable=0. Entering IDLE clears prescaler and scan index to 0.
- SCAN: prescaler counts 0..PRESCALE-1 and wraps; on terminal count (PRESCALE-1) index advances, DIGITS-1 wraps to 0. PRESCALE=1 advances index every cycle.
- Decode (per shadow digit at current index): 0→0x3F, 1→0x06, 2→0x5B, 3→0x4F, 4→0x66, 5→0x6D, 6→0x7D, 7→0x07, 8→0x7F, 9→0x6F, 10–15→0x40 (dash).
- err = OR over shadow digits of (digit > 9), registered.
- Reset (asynchronous, reset=0): state IDLE, prescaler 0, index 0, shadow 0, seg_out 0x00, digit_sel 0, err 0 — immediately, including mid-scan.

## Timing
- All outputs registered; no combinational input→output path.
- seg_out/digit_sel reflect index and shadow value of the previous cycle (1-cycle latency). First edge with enable=1 moves to SCAN; next edge drives digit_sel=1<<0.
- Each digit_sel value is held exactly PRESCALE consecutive cycles; full frame = DIGITS*PRESCALE cycles.
- digits_in change → seg_out change: 2 cycles (shadow capture + output register) when the digit is selected and hold=0.
- enable falling: seg_out and digit_sel are 0 on the edge after the first edge sampling enable=0.
- hold and a digits_in change on the same edge: hold wins; shadow keeps old value.
- err updates 2 cycles after an invalid digit appears (hold=0), regardless of enable.

## Configuration
- BCD_LEADING_ZERO_BLANK_EN defined: for index k≥1, if shadow digit k and all digits above it are 0, seg_out=0x00 for that slot; digit_sel still strobes (constant brightness). Digit 0 never blanked; all-zero value shows a single "0".
- Not defined: every digit decoded as listed, zeros shown as 0x3F.

## Structure
- Package bcd_display_pkg: typedef seg_t (logic [6:0]), typedef scan_state_t enum {IDLE, SCAN}, SEG_0..SEG_9 and SEG_DASH constants.
- Sub-module seg7_decoder: combinational 4-bit BCD → seg_t, instantiated once on the muxed digit.
- Top holds shadow register, prescaler, index, FSM, blanking logic and output registers.

## Test plan
- Reset: assert reset=0 mid-scan with digit_sel=0b0100 → seg_out=0x00, digit_sel=0, err=0 immediately, before the next edge.
- Scan order (DIGITS=4, PRESCALE=2, digits_in=0x4321, enable=1): digit_sel 0001,0001,0010,0010,0100,0100,1000,1000,0001…; seg_out 0x06,0x5B,0x4F,0x66 in step.
- Enable drop: enable→0 during digit 2 → outputs blank one cycle later; re-enable restarts at digit_sel=0001 with full PRESCALE dwell.
- Hold: digits_in=0x0009, hold=1, then digits_in=0x0005 → digit 0 still 0x6F; hold=0 → 0x6D within 2 cycles.
- Invalid digit: digits_in=0x00A0 → err=1 after 2 cycles, digit 1 shows 0x40; return to 0x0000 → err=0.
- Blanking (macro defined): digits_in=0x0070 → digits 3,2 seg_out=0x00, digit 1 0x07, digit 0 0x3F; macro undefined → digits 3,2 show 0x3F.

Source files
------------

// File: rtl/bcd_display_pkg.sv
// bcd_display_pkg
//   Shared types and segment constants for the BCD scan driver.
//   seg_t        : 7-bit segment vector, bit 0 = a ... bit 6 = g, active-high.
//   scan_state_t : scanner FSM states (IDLE, SCAN).
//   SEG_0..SEG_9 : patterns for decimal digits; SEG_DASH for non-BCD codes.
package bcd_display_pkg;

    typedef logic [6:0] seg_t;

    typedef enum logic {
        IDLE,
        SCAN
    } scan_state_t;

    localparam seg_t SEG_0    = 7'h3F;
    localparam seg_t SEG_1    = 7'h06;
    localparam seg_t SEG_2    = 7'h5B;
    localparam seg_t SEG_3    = 7'h4F;
    localparam seg_t SEG_4    = 7'h66;
    localparam seg_t SEG_5    = 7'h6D;
    localparam seg_t SEG_6    = 7'h7D;
    localparam seg_t SEG_7    = 7'h07;
    localparam seg_t SEG_8    = 7'h7F;
    localparam seg_t SEG_9    = 7'h6F;
    localparam seg_t SEG_DASH = 7'h40;

endpackage

// File: rtl/bcd_display_scan_seg7_decoder.sv
// seg7_decoder
//   Combinational BCD to 7-segment decoder; codes 10..15 show a dash.
//   digit : 4-bit BCD input
//   seg   : segment pattern, bit 0 = a ... bit 6 = g, active-high
module seg7_decoder
    import bcd_display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scan.sv
// bcd_display_scan
//   Time-multiplexed common-cathode 7-segment driver for a chain of
//   decade counters. Captures the packed BCD digits into a shadow register
//   (frozen by hold), rotates a one-hot digit strobe every PRESCALE cycles
//   and drives the decoded segment pattern of the selected digit.
//   Optional feature macro: BCD_LEADING_ZERO_BLANK_EN (leading-zero blanking).
//
//   Parameters: DIGITS   number of digits scanned (2..8), digit 0 = LSD
//               PRESCALE cycles each digit stays selected (>= 1)
//   Ports:      clock     system clock, rising edge
//               reset     asynchronous active-low reset
//               enable    scan enable; low blanks and parks the scanner
//               hold      freezes the captured digit values
//               digits_in packed BCD digits, digit k at [4k+3:4k]
//               seg_out   registered segment pattern, bit 0 = a
//               digit_sel registered one-hot digit strobe, zero when blank
//               err       registered flag: some captured digit > 9
module bcd_display_scan
    import bcd_display_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned PRESCALE = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  hold,
    input  logic [4*DIGITS-1:0]   digits_in,
    output logic [6:0]            seg_out,
    output logic [DIGITS-1:0]     digit_sel,
    output logic                  err
);

    localparam int unsigned IW = $clog2(DIGITS);
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [DIGITS-1:0][3:0] shadow;
    scan_state_t            state;
    scan_state_t            state_next;
    logic [PW-1:0]          presc;
    logic [PW-1:0]          presc_next;
    logic [IW-1:0]          idx;
    logic [IW-1:0]          idx_next;

    logic                   scan_active;
    logic                   blank_slot;
    logic                   any_invalid;
    logic [3:0]             cur_digit;
    seg_t                   dec_seg;

    // Shadow capture runs regardless of enable so err tracks the input.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shadow <= '0;
        end else if (!hold) begin
            shadow <= digits_in;
        end
    end

    // FSM: state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            presc <= '0;
            idx   <= '0;
        end else begin
            state <= state_next;
            presc <= presc_next;
            idx   <= idx_next;
        end
    end

    // FSM: next state, prescaler and scan index
    always_comb begin
        state_next = state;
        presc_next = presc;
        idx_next   = idx;
        case (state)
            IDLE: begin
                presc_next = '0;
                idx_next   = '0;
                if (enable) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (!enable) begin
                    state_next = IDLE;
                    presc_next = '0;
                    idx_next   = '0;
                end else if (presc == PW'(PRESCALE - 1)) begin
                    presc_next = '0;
                    idx_next   = (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
                end else begin
                    presc_next = presc + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                presc_next = '0;
                idx_next   = '0;
            end
        endcase
    end

    // FSM: output decode (feeds the output registers)
    always_comb begin
        scan_active = (state == SCAN);
        cur_digit   = shadow[idx];
    end

    always_comb begin
        any_invalid = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            any_invalid = any_invalid | (shadow[i] > 4'd9);
        end
    end

`ifdef BCD_LEADING_ZERO_BLANK_EN
    // zero_above[k] is set when digit k and every more significant digit
    // are zero; walked from the MSD down so each stage reuses the one above.
    logic [DIGITS-1:0] zero_above;
    logic              run;

    always_comb begin
        run        = 1'b1;
        zero_above = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            run                       = run & (shadow[DIGITS-1-i] == 4'd0);
            zero_above[DIGITS-1-i]    = run;
        end
        blank_slot = (idx != '0) && zero_above[idx];
    end
`else
    always_comb begin
        blank_slot = 1'b0;
    end
`endif

    seg7_decoder u_decoder (
        .digit (cur_digit),
        .seg   (dec_seg)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            seg_out   <= '0;
            digit_sel <= '0;
            err       <= 1'b0;
        end else begin
            seg_out   <= (scan_active && !blank_slot) ? dec_seg : '0;
            digit_sel <= scan_active ? (DIGITS'(1) << idx) : '0;
            err       <= any_invalid;
        end
    end

endmodule
